// File: rtl/counter8b_sweep_ctrl_pkg.sv
// Shared encodings and default widths for the triangle-sweep sequencer.
package counter8b_sweep_ctrl_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SWEEP_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/counter8b_updown_ld.sv
// Loadable up/down count register; load takes priority over counting.
module counter8b_updown_ld
  import counter8b_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= (i_dir == DIR_UP) ? r_count + 1'b1 : r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter8b_sweep_ctrl.sv
// Triangle-sweep sequencer: runs the count between latched lo/hi limits for a
// programmed number of periods, with start/abort handshake and done/err pulses.
module counter8b_sweep_ctrl
  import counter8b_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t               r_state;
  logic                 r_dir;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_hi;
  logic [SWEEP_W-1:0]   r_n;
  logic [SWEEP_W-1:0]   r_period;

  logic [WIDTH-1:0]     w_count;
  logic                 w_load;
  logic                 w_en;
  logic                 w_cnt_dir;
  logic [SWEEP_W-1:0]   w_period_next;
  logic                 w_last;

  assign w_period_next = r_period + 1'b1;
  // A zero period count means free-running: the counter wraps and is ignored.
  assign w_last        = (r_n != '0) && (w_period_next == r_n);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_load    = 1'b0;
    w_en      = 1'b0;
    w_cnt_dir = DIR_UP;
    case (r_state)
      ST_IDLE: w_load = start && !abort && (lo < hi);
      ST_UP: begin
        if (!abort) begin
          w_en      = 1'b1;
          w_cnt_dir = (w_count == r_hi) ? DIR_DOWN : DIR_UP;
        end
      end
      ST_DOWN: begin
        if (!abort) begin
          if (w_count != r_lo) begin
            w_en      = 1'b1;
            w_cnt_dir = DIR_DOWN;
          end else if (!w_last) begin
            w_en      = 1'b1;
            w_cnt_dir = DIR_UP;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the shadow limit registers are reset along with control state so
  // the block powers up fully defined; they are only read while busy anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dir    <= DIR_UP;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_n      <= '0;
      r_period <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (lo >= hi) begin
              r_err <= 1'b1;
            end else begin
              r_lo     <= lo;
              r_hi     <= hi;
              r_n      <= n_sweeps;
              r_period <= '0;
              r_busy   <= 1'b1;
              r_dir    <= DIR_UP;
              r_state  <= ST_UP;
            end
          end
        end
        ST_UP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dir   <= DIR_UP;
          end else if (w_count == r_hi) begin
            r_state <= ST_DOWN;
            r_dir   <= DIR_DOWN;
          end
        end
        ST_DOWN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dir   <= DIR_UP;
          end else if (w_count == r_lo) begin
            r_period <= w_period_next;
            r_dir    <= DIR_UP;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_UP;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_dir   <= DIR_UP;
        end
      endcase
    end
  end

  counter8b_updown_ld #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (w_load),
    .i_load_val(lo),
    .i_en      (w_en),
    .i_dir     (w_cnt_dir),
    .o_count   (w_count)
  );

  assign count = w_count;
  assign dir   = r_dir;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_counter8b_sweep_ctrl.sv
// Bench for counter8b_sweep_ctrl: directed scenarios plus randomized stimulus
// checked every cycle against a closed-form triangle-wave model.
module tb_counter8b_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] n_sweeps;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;
  bit cmp_en;

  // Expected outputs after the most recent edge, and the latched run.
  int e_count, e_dir, e_busy, e_done, e_err;
  int m_lo, m_hi, m_n, m_k;

  counter8b_sweep_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .lo      (lo),
    .hi      (hi),
    .n_sweeps(n_sweeps),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Run position k edges after start: t = k mod P along a triangle of
  // half-period D = hi-lo; the run ends on edge n*P+1 with count at lo.
  task automatic model_edge();
    int d, p, t;
    e_done = 0;
    e_err  = 0;
    if (e_busy == 0) begin
      if (start && !abort) begin
        if (lo >= hi) begin
          e_err = 1;
        end else begin
          m_lo = lo; m_hi = hi; m_n = n_sweeps; m_k = 0;
          e_busy = 1; e_count = lo; e_dir = 1;
        end
      end
    end else if (abort) begin
      e_busy = 0;
      e_dir  = 1;
    end else begin
      d = m_hi - m_lo;
      p = 2 * d;
      m_k++;
      if (m_n != 0 && m_k == m_n * p + 1) begin
        e_busy = 0; e_done = 1; e_count = m_lo; e_dir = 1;
      end else begin
        t = m_k % p;
        e_count = m_lo + ((t <= d) ? t : p - t);
        e_dir   = (t >= 1 && t <= d) ? 1 : 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      check("count", count, e_count);
      check("dir",   dir,   e_dir);
      check("busy",  busy,  e_busy);
      check("done",  done,  e_done);
      check("err",   err,   e_err);
    end
  end

  task automatic step(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_dir",   dir,   1);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_err",   err,   0);
    e_count = 0; e_dir = 1; e_busy = 0; e_done = 0; e_err = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int seq1[7]  = '{2, 3, 4, 5, 4, 3, 2};
    int dir1[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int seq2[7]  = '{10, 11, 10, 11, 10, 11, 10};
    int dir2[7]  = '{1, 1, 0, 1, 0, 1, 0};
    checks = 0; errors = 0; cmp_en = 1'b0;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0;
    e_count = 0; e_dir = 1; e_busy = 0; e_done = 0; e_err = 0;
    m_lo = 0; m_hi = 0; m_n = 0; m_k = 0;

    #12;
    check("init_count", count, 0);
    check("init_dir",   dir,   1);
    check("init_busy",  busy,  0);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Single period 2..5.
    lo = 8'd2; hi = 8'd5; n_sweeps = 4'd1;
    step(1'b1, 1'b0);
    check("t1_count0", count, seq1[0]);
    for (int i = 1; i < 7; i++) begin
      step(1'b0, 1'b0);
      check("t1_count", count, seq1[i]);
      check("t1_dir",   dir,   dir1[i]);
      check("t1_busy",  busy,  1);
    end
    step(1'b0, 1'b0);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_hold", count, 2);
    step(1'b0, 1'b0);
    check("t1_done_pulse", done, 0);

    // Narrowest window, three periods.
    lo = 8'd10; hi = 8'd11; n_sweeps = 4'd3;
    step(1'b1, 1'b0);
    check("t2_count0", count, seq2[0]);
    for (int i = 1; i < 7; i++) begin
      step(1'b0, 1'b0);
      check("t2_count", count, seq2[i]);
      check("t2_dir",   dir,   dir2[i]);
    end
    step(1'b0, 1'b0);
    check("t2_done", done, 1);
    check("t2_hold", count, 10);

    // Rejected start, then start masked by abort.
    lo = 8'd5; hi = 8'd5; n_sweeps = 4'd1;
    step(1'b1, 1'b0);
    check("t4_err",   err,   1);
    check("t4_busy",  busy,  0);
    check("t4_count", count, 10);
    step(1'b0, 1'b0);
    check("t4_err_pulse", err, 0);
    lo = 8'd3; hi = 8'd9;
    step(1'b1, 1'b1);
    check("t4_sa_busy", busy,  0);
    check("t4_sa_err",  err,   0);
    check("t4_sa_cnt",  count, 10);
    step(1'b0, 1'b0);

    // Full range, free-running, then abort.
    lo = 8'd0; hi = 8'd255; n_sweeps = 4'd0;
    step(1'b1, 1'b0);
    repeat (255) step(1'b0, 1'b0);
    check("t3_top", count, 255);
    step(1'b0, 1'b0);
    check("t3_turn", count, 254);
    repeat (254) step(1'b0, 1'b0);
    check("t3_bottom", count, 0);
    step(1'b0, 1'b0);
    check("t3_rise", count, 1);
    check("t3_busy", busy, 1);
    step(1'b0, 1'b1);
    check("t3_abort_busy",  busy,  0);
    check("t3_abort_count", count, 1);
    check("t3_abort_done",  done,  0);
    step(1'b0, 1'b0);
    check("t3_frozen", count, 1);

    // Shadowed limits: changes and start mid-DOWN are ignored.
    lo = 8'd2; hi = 8'd6; n_sweeps = 4'd2;
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    check("t5_count", count, 4);
    check("t5_dir",   dir,   0);
    lo = 8'd0; hi = 8'd200; n_sweeps = 4'd0;
    step(1'b1, 1'b0);
    check("t5_ign1", count, 3);
    step(1'b0, 1'b0);
    check("t5_ign2", count, 2);
    step(1'b0, 1'b0);
    check("t5_ign3", count, 3);
    check("t5_dir2", dir, 1);
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 4) == 0) begin
          lo = 8'($urandom_range(0, 30));
          if ($urandom_range(0, 5) == 0) hi = 8'($urandom);
          else hi = lo + 8'($urandom_range(0, 8));
          n_sweeps = 4'($urandom_range(0, 3));
        end
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
